// File: rtl/cpu_if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue feeding ID over valid/ready.
// Fetch issues one word per cycle while credit remains; jumps redirect, flush and drop the in-flight response.
module cpu_if_prefetch #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     halt_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic [31:0]              imem_data_i,
    input  logic [31:0]              jmp_addr_i,
    input  logic                     jmp_valid_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              ir_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 2;

    localparam logic [31:0] NOP_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_req_addr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_pc_mem [DEPTH];
    logic [31:0]   r_ir_mem [DEPTH];

    logic [31:0]   w_jmp_target;
    logic [SW-1:0] w_credit_sum;
    logic          w_pop;
    logic          w_push;

    assign w_jmp_target = jmp_addr_i & 32'hFFFF_FFFC;

    assign valid_o = (r_count != '0) && !jmp_valid_i;
    assign w_pop   = valid_o && ready_i;
    assign w_push  = r_inflight && !jmp_valid_i;

    // Occupancy the queue will hold once the outstanding response lands; pop frees a slot this cycle.
    assign w_credit_sum = SW'(r_count) + SW'(r_inflight) - SW'(w_pop);

    // Gated with reset so the request line is quiet while reset is asserted.
    assign imem_req_o  = reset_n_i && !halt_i &&
                         (jmp_valid_i || (w_credit_sum < SW'(DEPTH)));
    assign imem_addr_o = jmp_valid_i ? w_jmp_target : r_fetch_pc;

    assign pc_o    = valid_o ? r_pc_mem[r_rd_ptr] : NOP_PC;
    assign ir_o    = valid_o ? r_ir_mem[r_rd_ptr] : NOP_IR;
    assign level_o = r_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fetch_pc <= RESET_VECTOR;
            r_inflight <= 1'b0;
            r_req_addr <= RESET_VECTOR;
        end else begin
            r_inflight <= imem_req_o;
            r_req_addr <= imem_addr_o;
            if (imem_req_o) begin
                r_fetch_pc <= imem_addr_o + 32'd4;
            end else if (jmp_valid_i) begin
                r_fetch_pc <= w_jmp_target;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (jmp_valid_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage carries no reset; empty entries are masked by valid_o.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr] <= r_req_addr;
            r_ir_mem[r_wr_ptr] <= imem_data_i;
        end
    end

endmodule

// File: tb/tb_cpu_if_prefetch.sv
// Directed bench for cpu_if_prefetch (DEPTH=4, RESET_VECTOR=0) with a one-cycle-latency memory model.
// Memory returns addr ^ 32'hA5A50000 for the address presented on the previous edge.
module tb_cpu_if_prefetch;

    localparam logic [31:0] NOP_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;
    localparam logic [31:0] XMASK  = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        halt_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'h0;
    logic [31:0] jmp_addr_i;
    logic        jmp_valid_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] ir_o;
    logic [2:0]  level_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;
    int n_xfer;

    cpu_if_prefetch #(.DEPTH(4), .RESET_VECTOR(32'h0)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .halt_i      (halt_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_i (imem_data_i),
        .jmp_addr_i  (jmp_addr_i),
        .jmp_valid_i (jmp_valid_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .ir_o        (ir_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) imem_data_i <= imem_addr_o ^ XMASK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk_head(input string tag);
        chk({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
        chk({tag, "_pc"}, pc_o, exp_pc);
        chk({tag, "_ir"}, ir_o, exp_pc ^ XMASK);
        $display("xfer %s pc=%h ir=%h", tag, pc_o, ir_o);
        exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i   = 1'b0;
        halt_i      = 1'b0;
        jmp_valid_i = 1'b0;
        jmp_addr_i  = 32'h0;
        ready_i     = 1'b0;
        #3;
        chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, valid_o},    32'd0);
        chk("rst_pc",    pc_o,                NOP_PC);
        chk("rst_ir",    ir_o,                NOP_IR);
        chk("rst_level", {29'b0, level_o},    32'd0);

        // Streaming with ID always ready
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        ready_i   = 1'b1;
        #1;
        chk("c0_req",   {31'b0, imem_req_o}, 32'd1);
        chk("c0_addr",  imem_addr_o,         32'h0);
        chk("c0_valid", {31'b0, valid_o},    32'd0);
        tick();
        chk("c1_addr",  imem_addr_o,         32'h4);
        chk("c1_valid", {31'b0, valid_o},    32'd0);
        tick();
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            chk_head("stream");
            tick();
        end

        // Backpressure: fill to DEPTH, then release
        ready_i = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) tick();
        chk("full_level", {29'b0, level_o},    32'd4);
        chk("full_req",   {31'b0, imem_req_o}, 32'd0);
        chk("full_pc",    pc_o,                32'd24);
        ready_i = 1'b1;
        #1;
        chk("rel_req",  {31'b0, imem_req_o}, 32'd1);
        chk("rel_addr", imem_addr_o,         32'd40);
        for (int i = 0; i < 8; i++) begin
            chk_head("drain");
            tick();
        end

        // Jump with 3 queued and one in flight
        chk("prejmp_level", {29'b0, level_o}, 32'd3);
        jmp_valid_i = 1'b1;
        jmp_addr_i  = 32'h103;
        #1;
        chk("jmp_addr",  imem_addr_o,         32'h100);
        chk("jmp_req",   {31'b0, imem_req_o}, 32'd1);
        chk("jmp_valid", {31'b0, valid_o},    32'd0);
        tick();
        jmp_valid_i = 1'b0;
        jmp_addr_i  = 32'h0;
        #1;
        chk("postjmp_level", {29'b0, level_o}, 32'd0);
        chk("postjmp_valid", {31'b0, valid_o}, 32'd0);
        chk("postjmp_addr",  imem_addr_o,      32'h104);
        tick();
        exp_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            chk_head("target");
            tick();
        end

        // Halt: no requests, in-flight delivered, queue drains
        halt_i = 1'b1;
        #1;
        n_xfer = 0;
        for (int i = 0; i < 5; i++) begin
            chk("halt_req", {31'b0, imem_req_o}, 32'd0);
            if (valid_o) begin
                chk_head("halt");
                n_xfer++;
            end
            tick();
        end
        chk("halt_xfers", n_xfer,             32'd2);
        chk("halt_level", {29'b0, level_o},    32'd0);
        chk("halt_valid", {31'b0, valid_o},    32'd0);
        halt_i = 1'b0;
        #1;
        chk("unhalt_req",  {31'b0, imem_req_o}, 32'd1);
        chk("unhalt_addr", imem_addr_o,         32'h118);
        tick();
        tick();
        chk_head("resume");

        // Jump while halted
        tick();
        halt_i = 1'b1;
        #1;
        chk("hj_req0", {31'b0, imem_req_o}, 32'd0);
        tick();
        jmp_valid_i = 1'b1;
        jmp_addr_i  = 32'h2002;
        #1;
        chk("hj_req1",   {31'b0, imem_req_o}, 32'd0);
        chk("hj_valid",  {31'b0, valid_o},    32'd0);
        tick();
        jmp_valid_i = 1'b0;
        jmp_addr_i  = 32'h0;
        #1;
        chk("hj_req2",   {31'b0, imem_req_o}, 32'd0);
        chk("hj_level",  {29'b0, level_o},    32'd0);
        tick();
        halt_i = 1'b0;
        #1;
        chk("hj_rel_req",  {31'b0, imem_req_o}, 32'd1);
        chk("hj_rel_addr", imem_addr_o,         32'h2000);
        tick();
        tick();
        exp_pc = 32'h2000;
        chk_head("hjtarget");

        // Reset pulse between edges
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("mrst_req",   {31'b0, imem_req_o}, 32'd0);
        chk("mrst_valid", {31'b0, valid_o},    32'd0);
        chk("mrst_pc",    pc_o,                NOP_PC);
        chk("mrst_ir",    ir_o,                NOP_IR);
        chk("mrst_level", {29'b0, level_o},    32'd0);
        #1;
        reset_n_i = 1'b1;
        #1;
        chk("mrst_rel_req",  {31'b0, imem_req_o}, 32'd1);
        chk("mrst_rel_addr", imem_addr_o,         32'h0);
        tick();
        chk("mrst_c1_level", {29'b0, level_o}, 32'd0);
        chk("mrst_c1_valid", {31'b0, valid_o}, 32'd0);
        tick();
        exp_pc = 32'h0;
        chk_head("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
